store_buffer: RTL and testbench

Write buffer between the store stage and data memory. Accepts one word store per cycle (`address`, `write_data`, `write_enable` from the store stage), queues it in a DEPTH-entry FIFO, and drains entries in order to data memory over a req/ack handshake. Provides store-to-load forwarding, so a load issued while its store is still queued sees the newest data. Asserts `full` to stall the store stage.

---
 rtl/store_buffer_if.sv | 42 ++++
 rtl/store_buffer.sv | 103 ++++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bundles the store-stage, memory-drain and load-forwarding signals of the store buffer.
// The slave modport faces the buffer; the master modport faces its environment.
interface store_buffer_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   // Store stage
   logic              write_enable;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic              full;
   logic              empty;
   logic [CntW-1:0]   count;
   logic              misaligned;
   logic              overflow;

   // Memory drain
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;

   // Load forwarding
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;

   modport master (
      output write_enable, address, write_data, mem_ack, ld_addr,
      input  full, empty, count, misaligned, overflow,
      input  mem_req, mem_addr, mem_wdata, ld_hit, ld_data
   );

   modport slave (
      input  write_enable, address, write_data, mem_ack, ld_addr,
      output full, empty, count, misaligned, overflow,
      output mem_req, mem_addr, mem_wdata, ld_hit, ld_data
   );
endinterface

// File: rtl/store_buffer.sv
// In-order write buffer between the store stage and data memory, with
// store-to-load forwarding of the youngest queued store to a matching word address.
module store_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   store_buffer_if.slave  bus
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PtrW-1:0]   r_wr_ptr;
   logic [PtrW-1:0]   r_rd_ptr;
   logic [CntW-1:0]   r_count;
   logic              r_misaligned;
   logic              r_overflow;

   logic              w_full;
   logic              w_empty;
   logic              w_aligned;
   logic              w_push;
   logic              w_pop;
   logic              w_reject_mis;
   logic              w_reject_full;
   logic [ADDR_W-1:0] w_ld_word;
   logic [PtrW-1:0]   w_idx;
   logic              w_ld_hit;
   logic [DATA_W-1:0] w_ld_data;

   assign w_full    = (r_count == CntFull);
   assign w_empty   = (r_count == '0);
   assign w_aligned = (bus.address[1:0] == 2'b00);

   // Push/reject decisions use the pre-edge count, so a full buffer rejects
   // even when the head is popped in the same cycle.
   assign w_push        = bus.write_enable && w_aligned && !w_full;
   assign w_reject_mis  = bus.write_enable && !w_aligned;
   assign w_reject_full = bus.write_enable && w_aligned && w_full;
   assign w_pop         = !w_empty && bus.mem_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_misaligned <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_push) begin
            r_addr[r_wr_ptr] <= bus.address;
            r_data[r_wr_ptr] <= bus.write_data;
            r_wr_ptr         <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
         r_misaligned <= w_reject_mis;
         r_overflow   <= w_reject_full;
      end
   end

   // Walk entries oldest to youngest so the last match (youngest) wins.
   assign w_ld_word = bus.ld_addr >> 2;

   always_comb begin
      w_ld_hit  = 1'b0;
      w_ld_data = '0;
      w_idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + PtrW'(i);
         if ((CntW'(i) < r_count) && ((r_addr[w_idx] >> 2) == w_ld_word)) begin
            w_ld_hit  = 1'b1;
            w_ld_data = r_data[w_idx];
         end
      end
   end

   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.count      = r_count;
   assign bus.misaligned = r_misaligned;
   assign bus.overflow   = r_overflow;
   assign bus.mem_req    = !w_empty;
   assign bus.mem_addr   = r_addr[r_rd_ptr];
   assign bus.mem_wdata  = r_data[r_rd_ptr];
   assign bus.ld_hit     = w_ld_hit;
   assign bus.ld_data    = w_ld_data;
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: reset, drain, fill/overflow,
// forwarding, pointer wrap under concurrent push/pop, misalignment and mid-drain reset.
module tb_store_buffer;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb_if ();

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sb_if.write_enable = 1'b0;
      sb_if.address      = '0;
      sb_if.write_data   = '0;
      sb_if.mem_ack      = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      sb_if.write_enable = 1'b1;
      sb_if.address      = a;
      sb_if.write_data   = d;
      tick();
      sb_if.write_enable = 1'b0;
   endtask

   initial begin
      logic [31:0] fill_addr [4];
      n_checks = 0;
      n_fail   = 0;
      fill_addr = '{32'h00, 32'h04, 32'h08, 32'h0C};
      idle_inputs();
      sb_if.ld_addr = '0;

      // Reset
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_eq("rst_empty", sb_if.empty, 1);
      check_eq("rst_full", sb_if.full, 0);
      check_eq("rst_count", sb_if.count, 0);
      check_eq("rst_mem_req", sb_if.mem_req, 0);
      check_eq("rst_mem_addr", sb_if.mem_addr, 0);
      check_eq("rst_mem_wdata", sb_if.mem_wdata, 0);
      check_eq("rst_misaligned", sb_if.misaligned, 0);
      check_eq("rst_overflow", sb_if.overflow, 0);
      check_eq("rst_ld_hit", sb_if.ld_hit, 0);
      check_eq("rst_ld_data", sb_if.ld_data, 0);

      // Single store, held while unacknowledged
      push(32'h10, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         check_eq("single_req", sb_if.mem_req, 1);
         check_eq("single_addr", sb_if.mem_addr, 32'h10);
         check_eq("single_data", sb_if.mem_wdata, 32'hDEAD_BEEF);
         tick();
      end
      sb_if.mem_ack = 1'b1;
      tick();
      sb_if.mem_ack = 1'b0;
      check_eq("single_empty", sb_if.empty, 1);
      check_eq("single_req_low", sb_if.mem_req, 0);

      // Ack with nothing queued is ignored
      sb_if.mem_ack = 1'b1;
      tick();
      sb_if.mem_ack = 1'b0;
      check_eq("idle_ack_count", sb_if.count, 0);

      // Fill and overflow
      for (int i = 0; i < 4; i++) begin
         check_eq("fill_not_full", sb_if.full, 0);
         push(fill_addr[i], 32'hF000_0000 + 32'(i));
      end
      check_eq("fill_full", sb_if.full, 1);
      check_eq("fill_count", sb_if.count, 4);
      push(32'h10, 32'h5555_5555);
      check_eq("ovf_pulse", sb_if.overflow, 1);
      check_eq("ovf_count", sb_if.count, 4);
      tick();
      check_eq("ovf_pulse_end", sb_if.overflow, 0);
      // Misaligned wins over full
      push(32'h11, 32'h6666_6666);
      check_eq("mis_prio_mis", sb_if.misaligned, 1);
      check_eq("mis_prio_ovf", sb_if.overflow, 0);
      // Full buffer rejects even with a same-cycle pop
      sb_if.mem_ack = 1'b1;
      push(32'h14, 32'h7777_7777);
      sb_if.mem_ack = 1'b0;
      check_eq("ovf_pop_pulse", sb_if.overflow, 1);
      check_eq("ovf_pop_count", sb_if.count, 3);
      for (int i = 1; i < 4; i++) begin
         check_eq("drain_addr", sb_if.mem_addr, fill_addr[i]);
         check_eq("drain_data", sb_if.mem_wdata, 32'hF000_0000 + 32'(i));
         sb_if.mem_ack = 1'b1;
         tick();
      end
      sb_if.mem_ack = 1'b0;
      check_eq("drain_empty", sb_if.empty, 1);

      // Forwarding
      push(32'h20, 32'h1111_1111);
      push(32'h20, 32'h2222_2222);
      sb_if.ld_addr = 32'h22;
      #1;
      check_eq("fwd_hit", sb_if.ld_hit, 1);
      check_eq("fwd_data", sb_if.ld_data, 32'h2222_2222);
      sb_if.ld_addr = 32'h24;
      #1;
      check_eq("fwd_miss_hit", sb_if.ld_hit, 0);
      check_eq("fwd_miss_data", sb_if.ld_data, 0);
      // Same-cycle push is not yet visible
      sb_if.ld_addr      = 32'h30;
      sb_if.write_enable = 1'b1;
      sb_if.address      = 32'h30;
      sb_if.write_data   = 32'h3333_3333;
      #1;
      check_eq("fwd_same_cycle", sb_if.ld_hit, 0);
      tick();
      sb_if.write_enable = 1'b0;
      check_eq("fwd_next_cycle", sb_if.ld_hit, 1);
      check_eq("fwd_next_data", sb_if.ld_data, 32'h3333_3333);
      sb_if.mem_ack = 1'b1;
      tick();
      tick();
      tick();
      sb_if.mem_ack = 1'b0;
      check_eq("fwd_drained", sb_if.empty, 1);

      // Wrap and concurrency: 11 pushes, ack from the second on
      for (int k = 0; k < 11; k++) begin
         sb_if.write_enable = 1'b1;
         sb_if.address      = 32'h100 + 32'(4 * k);
         sb_if.write_data   = 32'hA000 + 32'(k);
         sb_if.mem_ack      = (k > 0);
         tick();
         check_eq("wrap_count", sb_if.count, 1);
         check_eq("wrap_addr", sb_if.mem_addr, 32'h100 + 32'(4 * k));
         check_eq("wrap_data", sb_if.mem_wdata, 32'hA000 + 32'(k));
      end
      sb_if.write_enable = 1'b0;
      tick();
      sb_if.mem_ack = 1'b0;
      check_eq("wrap_empty", sb_if.empty, 1);

      // Misaligned store
      push(32'h03, 32'h4444_4444);
      check_eq("mis_pulse", sb_if.misaligned, 1);
      check_eq("mis_count", sb_if.count, 0);
      tick();
      check_eq("mis_pulse_end", sb_if.misaligned, 0);

      // Reset mid-operation, overriding a simultaneous push and pop
      push(32'h40, 32'h40);
      push(32'h44, 32'h44);
      push(32'h48, 32'h48);
      sb_if.ld_addr = 32'h44;
      #1;
      check_eq("mid_req", sb_if.mem_req, 1);
      check_eq("mid_hit", sb_if.ld_hit, 1);
      reset              = 1'b1;
      sb_if.write_enable = 1'b1;
      sb_if.address      = 32'h4C;
      sb_if.write_data   = 32'h4C;
      sb_if.mem_ack      = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      check_eq("mid_rst_req", sb_if.mem_req, 0);
      check_eq("mid_rst_count", sb_if.count, 0);
      check_eq("mid_rst_hit", sb_if.ld_hit, 0);
      check_eq("mid_rst_addr", sb_if.mem_addr, 0);
      sb_if.ld_addr = 32'h48;
      #1;
      check_eq("mid_rst_hit2", sb_if.ld_hit, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
